// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: packed per-master request/response lanes, the
// single downstream slave port, the local register write strobe and the grant vector.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 24
);
  // Upstream masters, master i in slice [i*W +: W]
  logic [NUM_M-1:0]        m_wb_cyc;
  logic [NUM_M-1:0]        m_wb_stb;
  logic [NUM_M-1:0]        m_wb_we;
  logic [NUM_M-1:0]        m_wb_8_burst;
  logic [NUM_M-1:0]        m_wb_4_burst;
  logic [2*NUM_M-1:0]      m_wb_sel;
  logic [ADDR_W*NUM_M-1:0] m_wb_adr;
  logic [DATA_W*NUM_M-1:0] m_wb_o_dat;
  logic [NUM_M-1:0]        m_wb_ack;
  logic [NUM_M-1:0]        m_wb_err;
  logic [DATA_W-1:0]       m_wb_i_dat;

  // Downstream slave
  logic                    s_wb_cyc;
  logic                    s_wb_stb;
  logic                    s_wb_we;
  logic                    s_wb_8_burst;
  logic                    s_wb_4_burst;
  logic [1:0]              s_wb_sel;
  logic [ADDR_W-1:0]       s_wb_adr;
  logic [DATA_W-1:0]       s_wb_o_dat;
  logic                    s_wb_ack;
  logic                    s_wb_err;
  logic [DATA_W-1:0]       s_wb_i_dat;

  // Local register write and grant status
  logic                    loc_we;
  logic [DATA_W-1:0]       loc_dat;
  logic [NUM_M-1:0]        grant;

  modport arb (
    input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_8_burst, m_wb_4_burst,
    input  m_wb_sel, m_wb_adr, m_wb_o_dat,
    output m_wb_ack, m_wb_err, m_wb_i_dat,
    output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_8_burst, s_wb_4_burst,
    output s_wb_sel, s_wb_adr, s_wb_o_dat,
    input  s_wb_ack, s_wb_err, s_wb_i_dat,
    output loc_we, loc_dat, grant
  );

  modport master (
    output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_8_burst, m_wb_4_burst,
    output m_wb_sel, m_wb_adr, m_wb_o_dat,
    input  m_wb_ack, m_wb_err, m_wb_i_dat, grant
  );

  modport slave (
    input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_8_burst, s_wb_4_burst,
    input  s_wb_sel, s_wb_adr, s_wb_o_dat,
    output s_wb_ack, s_wb_err, s_wb_i_dat,
    input  loc_we, loc_dat
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin N-master Wishbone arbiter/mux: whole-cycle grant lock, in-place
// local register write, and a stalled-slave timeout that answers with err.
module wb_rr_arbiter #(
  parameter int unsigned       NUM_M       = 2,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [ADDR_W-1:0] LOCAL_ADDR  = ADDR_W'(24'h001001)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  wb_rr_arbiter_if.arb bus
);
  localparam int unsigned       IDX_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned       TC_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TC_W-1:0]   TC_MAX   = TC_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_M - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_g;
  logic [IDX_W-1:0]   r_lg;
  logic [TC_W-1:0]    r_tc;

  logic [1:0]         w_sel [NUM_M];
  logic [ADDR_W-1:0]  w_adr [NUM_M];
  logic [DATA_W-1:0]  w_dat [NUM_M];

  logic               w_busy;
  logic [IDX_W-1:0]   w_mux;
  logic               w_own_cyc;
  logic               w_own_stb;
  logic               w_own_we;
  logic [ADDR_W-1:0]  w_own_adr;
  logic [DATA_W-1:0]  w_own_dat;
  logic               w_hit;
  logic               w_s_stb;
  logic               w_to;
  logic               w_ack_own;
  logic               w_err_own;
  logic [NUM_M-1:0]   w_onehot;
  logic [IDX_W-1:0]   w_next;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign w_sel[gi] = bus.m_wb_sel[2*gi +: 2];
    assign w_adr[gi] = bus.m_wb_adr[ADDR_W*gi +: ADDR_W];
    assign w_dat[gi] = bus.m_wb_o_dat[DATA_W*gi +: DATA_W];
  end

  // Owner lane; master 0 is presented while idle
  assign w_busy    = (r_state == S_BUSY);
  assign w_mux     = w_busy ? r_g : '0;
  assign w_own_cyc = bus.m_wb_cyc[w_mux];
  assign w_own_stb = bus.m_wb_stb[w_mux];
  assign w_own_we  = bus.m_wb_we[w_mux];
  assign w_own_adr = w_adr[w_mux];
  assign w_own_dat = w_dat[w_mux];

  assign w_hit   = w_busy & w_own_cyc & w_own_stb & w_own_we & (w_own_adr == LOCAL_ADDR);
  assign w_s_stb = w_busy & w_own_stb & ~w_hit;

  // Timeout fires only when nothing else answers in the same cycle
  assign w_to = (TIMEOUT_CYC != 0) && (r_tc == TC_MAX) && w_s_stb
                && !bus.s_wb_ack && !bus.s_wb_err;

  assign w_ack_own = w_busy & (bus.s_wb_ack | w_hit);
  assign w_err_own = w_busy & (bus.s_wb_err | w_to);
  assign w_onehot  = NUM_M'(1) << r_g;

  // Slave side; data fields forced low while reset is held
  assign bus.s_wb_cyc     = w_busy & w_own_cyc;
  assign bus.s_wb_stb     = w_s_stb;
  assign bus.s_wb_we      = ~i_rst & w_own_we;
  assign bus.s_wb_8_burst = ~i_rst & bus.m_wb_8_burst[w_mux];
  assign bus.s_wb_4_burst = ~i_rst & bus.m_wb_4_burst[w_mux];
  assign bus.s_wb_sel     = i_rst ? 2'b00 : w_sel[w_mux];
  assign bus.s_wb_adr     = i_rst ? '0 : w_own_adr;
  assign bus.s_wb_o_dat   = i_rst ? '0 : w_own_dat;

  assign bus.m_wb_ack   = w_ack_own ? w_onehot : '0;
  assign bus.m_wb_err   = w_err_own ? w_onehot : '0;
  assign bus.m_wb_i_dat = bus.s_wb_i_dat;
  assign bus.grant      = w_busy ? w_onehot : '0;
  assign bus.loc_we     = w_hit;
  assign bus.loc_dat    = w_own_dat;

  // First requester at or after lg+1, wrapping
  always_comb begin
    w_next  = r_lg;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      w_cand = IDX_W'((32'(r_lg) + k) % NUM_M);
      if (!w_found && bus.m_wb_cyc[w_cand]) begin
        w_next  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_lg    <= LAST_IDX;
      r_tc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BUSY;
            r_g     <= w_next;
            r_lg    <= w_next;
          end
        end
        S_BUSY: begin
          if (!w_own_cyc) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Counts unanswered strobe cycles; any response or idle strobe restarts it
      if ((r_state == S_IDLE) || !w_s_stb || w_ack_own || w_err_own) begin
        r_tc <= '0;
      end else if (r_tc != TC_MAX) begin
        r_tc <= r_tc + TC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scenario bench for wb_rr_arbiter (3 masters, short timeout): expectations are
// queued as stimulus is applied and popped when the arbiter responds.
module tb_wb_rr_arbiter;
  localparam int unsigned NM = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 24;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_M(NM), .DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_rr_arbiter #(
    .NUM_M(NM), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO), .LOCAL_ADDR(24'h001001)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic b8, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    bus.m_wb_cyc[i]            = cyc;
    bus.m_wb_stb[i]            = stb;
    bus.m_wb_we[i]             = we;
    bus.m_wb_8_burst[i]        = b8;
    bus.m_wb_4_burst[i]        = 1'b0;
    bus.m_wb_sel[i*2 +: 2]     = 2'b11;
    bus.m_wb_adr[i*AW +: AW]   = adr;
    bus.m_wb_o_dat[i*DW +: DW] = dat;
  endtask

  task automatic drop_all();
    for (int i = 0; i < int'(NM); i++) set_m(i, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    bus.s_wb_ack = 1'b0;
    bus.s_wb_err = 1'b0;
  endtask

  // Bounded wait for any nonzero grant; counts grant-free cycles seen on the way
  task automatic wait_grant(output bit ok, output int idle);
    int c;
    ok = 1'b0; idle = 0; c = 0;
    while (!ok && c < 20) begin
      @(negedge clk);
      if (bus.grant != '0) ok = 1'b1;
      else idle++;
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_all();
    bus.s_wb_i_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.s_wb_cyc, bus.s_wb_stb, bus.s_wb_we, bus.s_wb_adr} !== '0) begin
      n_fail++;
      $display("FAIL reset_slave: got %h expected 0", {bus.s_wb_cyc, bus.s_wb_stb, bus.s_wb_we, bus.s_wb_adr});
    end
    n_cmp++;
    if ({bus.m_wb_ack, bus.m_wb_err, bus.loc_we, bus.grant} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h expected 0", {bus.m_wb_ack, bus.m_wb_err, bus.loc_we, bus.grant});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] e;
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, '0);
    exp_q.push_back(32'({3'b010, 16'hBEEF}));
    @(negedge clk);
    n_cmp++;
    if (bus.s_wb_cyc !== 1'b0) begin
      n_fail++; $display("FAIL single_latency_n: got %b expected 0", bus.s_wb_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.s_wb_cyc, bus.s_wb_stb, bus.grant, bus.s_wb_adr} !== {1'b1, 1'b1, 3'b010, 24'h000100}) begin
      n_fail++;
      $display("FAIL single_grant: got %h expected %h", {bus.s_wb_cyc, bus.s_wb_stb, bus.grant, bus.s_wb_adr},
               {1'b1, 1'b1, 3'b010, 24'h000100});
    end
    tick();
    bus.s_wb_ack = 1'b1; bus.s_wb_i_dat = 16'hBEEF;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.m_wb_ack, bus.m_wb_i_dat} !== e[18:0]) begin
      n_fail++; $display("FAIL single_ack: got %h expected %h", {bus.m_wb_ack, bus.m_wb_i_dat}, e[18:0]);
    end
    tick();
    drop_all();
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    bit ok; int idle; int own;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    for (int i = 0; i < int'(NM); i++) set_m(i, 1'b1, 1'b1, 1'b0, 1'b0, AW'(32'h10 * i), '0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok, idle);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rr_wait_%0d: got no grant expected grant within 20 cycles", k); end
      own = int'(exp_q.pop_front());
      n_cmp++;
      if (bus.grant !== NM'(1 << own)) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", k, bus.grant, NM'(1 << own));
      end
      if (k > 0) begin
        n_cmp++;
        if (idle !== 1) begin n_fail++; $display("FAIL rr_dead_%0d: got %0d idle cycles expected 1", k, idle); end
      end
      tick();
      bus.s_wb_ack = 1'b1; bus.s_wb_i_dat = DW'(16'h1000 + k);
      @(negedge clk);
      n_cmp++;
      if (bus.m_wb_ack !== NM'(1 << own)) begin
        n_fail++; $display("FAIL rr_ack_%0d: got %b expected %b", k, bus.m_wb_ack, NM'(1 << own));
      end
      tick();
      bus.s_wb_ack = 1'b0;
      set_m(own, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      if (k == 3) drop_all();
      tick();
      if (k < 3) set_m(own, 1'b1, 1'b1, 1'b0, 1'b0, AW'(32'h10 * own), '0);
    end
    repeat (2) tick();
  endtask

  task automatic test_burst_lock();
    bit ok; int idle; logic [31:0] e;
    set_m(0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000200, '0);
    wait_grant(ok, idle);
    n_cmp++;
    if (!ok || bus.grant !== 3'b001) begin n_fail++; $display("FAIL burst_start: got %b expected 001", bus.grant); end
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000300, '0);
    for (int b = 0; b < 8; b++) exp_q.push_back(32'({3'b001, 1'b1, 3'b001, DW'(16'h2000 + b)}));
    for (int b = 0; b < 8; b++) begin
      bus.s_wb_ack = 1'b1; bus.s_wb_i_dat = DW'(16'h2000 + b);
      bus.m_wb_adr[0 +: AW] = AW'(24'h000200 + b);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.grant, bus.s_wb_8_burst, bus.m_wb_ack, bus.m_wb_i_dat} !== e[22:0]) begin
        n_fail++; $display("FAIL burst_beat_%0d: got %h expected %h", b,
                           {bus.grant, bus.s_wb_8_burst, bus.m_wb_ack, bus.m_wb_i_dat}, e[22:0]);
      end
      tick();
    end
    bus.s_wb_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    wait_grant(ok, idle);
    n_cmp++;
    if (!ok || bus.grant !== 3'b010 || idle !== 1) begin
      n_fail++; $display("FAIL burst_handover: got grant %b idle %0d expected grant 010 idle 1", bus.grant, idle);
    end
  endtask

  task automatic test_local();
    logic [31:0] e;
    tick();
    set_m(1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h001001, 16'h0003);
    exp_q.push_back(32'({3'b010, 1'b1, 16'h0003, 1'b0, 1'b1}));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.m_wb_ack, bus.loc_we, bus.loc_dat, bus.s_wb_stb, bus.s_wb_cyc} !== e[21:0]) begin
      n_fail++; $display("FAIL local_write: got %h expected %h",
                         {bus.m_wb_ack, bus.loc_we, bus.loc_dat, bus.s_wb_stb, bus.s_wb_cyc}, e[21:0]);
    end
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001001, '0);
    exp_q.push_back(32'({1'b1, 24'h001001, 1'b0, 3'b000}));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.s_wb_stb, bus.s_wb_adr, bus.loc_we, bus.m_wb_ack} !== e[28:0]) begin
      n_fail++; $display("FAIL local_read_fwd: got %h expected %h",
                         {bus.s_wb_stb, bus.s_wb_adr, bus.loc_we, bus.m_wb_ack}, e[28:0]);
    end
    tick();
    bus.s_wb_ack = 1'b1; bus.s_wb_i_dat = 16'h5A5A;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_wb_ack, bus.m_wb_i_dat} !== {3'b010, 16'h5A5A}) begin
      n_fail++; $display("FAIL local_read_ack: got %h expected %h", {bus.m_wb_ack, bus.m_wb_i_dat}, {3'b010, 16'h5A5A});
    end
    tick();
    drop_all();
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    bit ok; int idle; logic [31:0] e;
    set_m(2, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000400, '0);
    // {err, ack} per strobe cycle: err on 5th, then four silent cycles, then acks
    for (int c = 1; c <= 11; c++) begin
      if (c == 5)      exp_q.push_back(32'({3'b100, 3'b000}));
      else if (c >= 10) exp_q.push_back(32'({3'b000, 3'b100}));
      else             exp_q.push_back(32'd0);
    end
    wait_grant(ok, idle);
    n_cmp++;
    if (!ok || bus.grant !== 3'b100) begin n_fail++; $display("FAIL to_grant: got %b expected 100", bus.grant); end
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) begin
        tick();
        bus.s_wb_ack = (c >= 10);
        @(negedge clk);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.m_wb_err, bus.m_wb_ack} !== e[5:0]) begin
        n_fail++; $display("FAIL to_cycle_%0d: got %b expected %b", c, {bus.m_wb_err, bus.m_wb_ack}, e[5:0]);
      end
    end
    tick();
    drop_all();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int idle; logic [31:0] e;
    set_m(0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000500, '0);
    wait_grant(ok, idle);
    n_cmp++;
    if (!ok || bus.grant !== 3'b001) begin n_fail++; $display("FAIL rst_burst_start: got %b expected 001", bus.grant); end
    for (int b = 1; b <= 3; b++) begin
      tick();
      bus.s_wb_ack = 1'b1;
      if (b < 3) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_wb_cyc, bus.s_wb_stb, bus.s_wb_adr, bus.grant, bus.m_wb_ack, bus.m_wb_err} !== '0) begin
      n_fail++; $display("FAIL rst_async: got %h expected 0",
                         {bus.s_wb_cyc, bus.s_wb_stb, bus.s_wb_adr, bus.grant, bus.m_wb_ack, bus.m_wb_err});
    end
    bus.s_wb_ack = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000600, '0);
    exp_q.push_back(32'(3'b001));
    @(negedge clk);
    rst = 1'b0;
    wait_grant(ok, idle);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant !== e[2:0]) begin
      n_fail++; $display("FAIL rst_first_grant: got %b expected %b", bus.grant, e[2:0]);
    end
    tick();
    drop_all();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_local();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
